// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller and time base.
// Turns three debounced key levels into start/pause, lap and clear events,
// runs the RUN/PAUSE/LAP state machine, divides the system clock down to a
// centisecond tick and keeps the hh:mm:ss:cc count. The displayed fields are
// registered and show either the live count or a latched lap value.
//
// Key handshake: the keys are plain levels with no valid/ready pairing. An
// event is the cycle in which a level is 1 and was 0 on the previous cycle.
// At most one event is acted on per cycle (clear > start_pause > lap). The
// others from that cycle are dropped.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 500000,
    parameter int HOUR_MAX = 23
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_pause,
    input  logic       lap,
    input  logic       clear,
    output logic [5:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [6:0] m_sec,
    output logic       running,
    output logic       lap_hold,
    output logic       wrap
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_PAUSE     = 3'd2,
        S_LAP       = 3'd3,
        S_LAP_PAUSE = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          sp_prev;
    logic          lap_prev;
    logic          clr_prev;
    logic          ev_clr;
    logic          ev_sp;
    logic          ev_lap;

    logic          count_en;
    logic          hold_sel;
    logic          latch_lap;
    logic          zero_all;

    logic [PW-1:0] presc;
    logic          tick;

    logic [5:0]    cnt_hh;
    logic [5:0]    cnt_mm;
    logic [5:0]    cnt_ss;
    logic [6:0]    cnt_cc;
    logic          cc_max;
    logic          ss_max;
    logic          mm_max;
    logic          hh_max;
    logic          wrap_evt;
    logic          wrap_pend;

    logic [5:0]    lap_hh;
    logic [5:0]    lap_mm;
    logic [5:0]    lap_ss;
    logic [6:0]    lap_cc;

    // Previous key levels for rising-edge detection; cleared by reset so a
    // key held through reset produces one event once reset drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            sp_prev  <= 1'b0;
            lap_prev <= 1'b0;
            clr_prev <= 1'b0;
        end else begin
            sp_prev  <= start_pause;
            lap_prev <= lap;
            clr_prev <= clear;
        end
    end

    // Rising edges, reduced to the single highest-priority event.
    always_comb begin
        ev_clr = clear & ~clr_prev;
        ev_sp  = start_pause & ~sp_prev & ~ev_clr;
        ev_lap = lap & ~lap_prev & ~ev_clr & ~ev_sp;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the datapath controls decoded from state/events.
    always_comb begin
        state_next = state;
        latch_lap  = 1'b0;
        zero_all   = 1'b0;
        count_en   = (state == S_RUN) || (state == S_LAP);
        hold_sel   = (state == S_LAP) || (state == S_LAP_PAUSE);
        case (state)
            S_IDLE: begin
                if (ev_sp) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (ev_sp) begin
                    state_next = S_PAUSE;
                end else if (ev_lap) begin
                    state_next = S_LAP;
                    latch_lap  = 1'b1;
                end
            end
            S_PAUSE: begin
                if (ev_clr) begin
                    state_next = S_IDLE;
                    zero_all   = 1'b1;
                end else if (ev_sp) begin
                    state_next = S_RUN;
                end
            end
            S_LAP: begin
                if (ev_clr) begin
                    state_next = S_RUN;
                end else if (ev_sp) begin
                    state_next = S_LAP_PAUSE;
                end else if (ev_lap) begin
                    latch_lap = 1'b1;
                end
            end
            S_LAP_PAUSE: begin
                if (ev_clr) begin
                    state_next = S_IDLE;
                    zero_all   = 1'b1;
                end else if (ev_sp) begin
                    state_next = S_LAP;
                end else if (ev_lap) begin
                    state_next = S_PAUSE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Tick on the last prescaler count while the counter is advancing.
    always_comb begin
        tick = count_en && (presc == PW'(TICK_DIV - 1));
    end

    // Prescaler: free-runs while counting, holds a partial tick across a
    // pause, and is parked at zero while idle.
    always_ff @(posedge clock) begin
        if (reset || zero_all || (state == S_IDLE)) begin
            presc <= '0;
        end else if (count_en) begin
            if (tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // Field terminal values used by the carry chain.
    always_comb begin
        cc_max   = (cnt_cc == 7'd99);
        ss_max   = (cnt_ss == 6'd59);
        mm_max   = (cnt_mm == 6'd59);
        hh_max   = (cnt_hh == 6'(HOUR_MAX));
        wrap_evt = tick && cc_max && ss_max && mm_max && hh_max;
    end

    // Live hh:mm:ss:cc counter; every field moves on the same tick edge.
    always_ff @(posedge clock) begin
        if (reset || zero_all) begin
            cnt_hh <= '0;
            cnt_mm <= '0;
            cnt_ss <= '0;
            cnt_cc <= '0;
        end else if (tick) begin
            cnt_cc <= cc_max ? 7'd0 : cnt_cc + 7'd1;
            if (cc_max) begin
                cnt_ss <= ss_max ? 6'd0 : cnt_ss + 6'd1;
                if (ss_max) begin
                    cnt_mm <= mm_max ? 6'd0 : cnt_mm + 6'd1;
                    if (mm_max) begin
                        cnt_hh <= hh_max ? 6'd0 : cnt_hh + 6'd1;
                    end
                end
            end
        end
    end

    // Lap register captures the count as it stood before any same-cycle tick.
    always_ff @(posedge clock) begin
        if (reset || zero_all) begin
            lap_hh <= '0;
            lap_mm <= '0;
            lap_ss <= '0;
            lap_cc <= '0;
        end else if (latch_lap) begin
            lap_hh <= cnt_hh;
            lap_mm <= cnt_mm;
            lap_ss <= cnt_ss;
            lap_cc <= cnt_cc;
        end
    end

    // Rollover marker, delayed one stage so the pulse lines up with the
    // registered display showing 0:00:00:00.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrap_pend <= 1'b0;
        end else begin
            wrap_pend <= wrap_evt;
        end
    end

    // Registered display mux and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            hour     <= '0;
            minute   <= '0;
            second   <= '0;
            m_sec    <= '0;
            running  <= 1'b0;
            lap_hold <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            hour     <= hold_sel ? lap_hh : cnt_hh;
            minute   <= hold_sel ? lap_mm : cnt_mm;
            second   <= hold_sel ? lap_ss : cnt_ss;
            m_sec    <= hold_sel ? lap_cc : cnt_cc;
            running  <= count_en;
            lap_hold <= hold_sel;
            wrap     <= wrap_pend;
        end
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Sequencing controller and time-base for the stopwatch datapath. It takes the three debounced key levels (start/pause, lap, clear), runs the run/pause/lap state machine, and divides the system clock down to a 1/100 s tick. It also holds the hh:mm:ss:cc counter and drives the binary time fields that feed the bin2bcd/bcd2seg display chain. It replaces the ad-hoc run flag at the top level.

Parameters:
TICK_DIV, 500000, system clocks per centisecond tick (50 MHz -> 100 Hz); must be >= 2
HOUR_MAX, 23, last hour value before wrap to 0; must be <= 63

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; returns the block to IDLE with all counts zero
start_pause  input  1  debounced key level, 1 = pressed; the 0->1 edge is the event
lap  input  1  debounced key level, 1 = pressed; the 0->1 edge is the event
clear  input  1  debounced key level, 1 = pressed; the 0->1 edge is the event
hour  output  6  displayed hours, 0..HOUR_MAX
minute  output  6  displayed minutes, 0..59
second  output  6  displayed seconds, 0..59
m_sec  output  7  displayed centiseconds, 0..99
running  output  1  1 while the counter advances (RUN, LAP)
lap_hold  output  1  1 while the display shows a latched lap value (LAP, LAP_PAUSE)
wrap  output  1  single-cycle pulse when the count rolls HOUR_MAX:59:59:99 -> 0:00:00:00

Behaviour:
- Edge detect: one registered copy per key. Event = level & ~prev. A held key generates exactly one event. The prev registers reset to 0, so a key held through reset fires one event on the first cycle after reset.
- Event priority in one cycle: clear > start_pause > lap. The lower-priority events that cycle are discarded, not queued.
- States: IDLE (reset), RUN, PAUSE, LAP, LAP_PAUSE. Transitions occur on the clock edge after the event cycle.
  IDLE: start_pause -> RUN. lap and clear are ignored.
  RUN: start_pause -> PAUSE. lap -> LAP and latches the live count into the lap register. clear is ignored.
  PAUSE: start_pause -> RUN. clear -> IDLE and zeroes the counter and prescaler. lap is ignored.
  LAP: start_pause -> LAP_PAUSE. lap re-latches the live count (split) and stays in LAP. clear -> RUN and releases the display to live; the counter is not zeroed.
  LAP_PAUSE: start_pause -> LAP. lap -> PAUSE and releases the display to live. clear -> IDLE and zeroes everything.
- Prescaler: counts 0..TICK_DIV-1 only in RUN/LAP. Tick = prescaler at TICK_DIV-1 while counting; the prescaler then returns to 0. It holds its value in PAUSE/LAP_PAUSE, so a partial tick is kept across a pause. It is forced to 0 in IDLE.
- Counter cascade on tick: cc 99 -> 0 carries to ss; ss 59 -> 0 carries to mm; mm 59 -> 0 carries to hh; hh HOUR_MAX -> 0 asserts wrap for that one cycle. All fields update on the same edge.
- A tick and a lap event in the same cycle: the latched value is the pre-increment count.
- Display mux: outputs are registered. They show the lap register when lap_hold = 1 and the live counter otherwise. Outputs follow the count with 1-cycle latency.
- running and lap_hold are decoded from state and registered alongside the display outputs.
- Reset (any state, mid-count included), one cycle later: state = IDLE, all fields 0, prescaler 0, lap register 0, running = 0, lap_hold = 0, wrap = 0.
- No other input affects the counter; values never leave their stated ranges.

Test Plan:
(Bench uses TICK_DIV = 4, HOUR_MAX = 1.)
- Reset, then one start_pause press, run 400 clocks -> running = 1; m_sec reaches 99 and the next tick gives second = 1, m_sec = 0; 4 clocks per increment.
- In RUN, press lap at count 0:00:02:37, wait 40 clocks -> display frozen at 2/37 with lap_hold = 1. Second lap press shows the new live value. clear returns to live display, count not zeroed.
- In RUN, press start_pause with prescaler at 2, wait 50 clocks, press again -> count unchanged while paused; first tick after resume arrives after 2 clocks, not 4.
- Press clear and start_pause on the same cycle while in PAUSE -> state IDLE, all outputs 0, running = 0; start_pause discarded.
- From 1:59:59:99 in RUN, one tick -> all fields 0, wrap high for exactly 1 cycle, running stays 1.
- Assert reset in LAP_PAUSE with a nonzero count and lap register -> next cycle all outputs 0, IDLE. Key held high through reset gives exactly one event after release of reset.
